// File: rtl/frame_layer_sequencer.sv
// Per-frame scheduler for the shared VGA write port: starts each drawing
// engine in ascending layer order and forwards only the active layer's plots.
module frame_layer_sequencer #(
  parameter int NUM_LAYERS = 3,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int COLOUR_W   = 3,
  parameter int TO_W       = 16
) (
  input  logic                           clk_i,
  input  logic                           resetn_i,
  input  logic                           run_i,
  input  logic                           frame_tick_i,
  output logic [NUM_LAYERS-1:0]          layer_start_o,
  input  logic [NUM_LAYERS-1:0]          layer_done_i,
  input  logic [NUM_LAYERS-1:0]          layer_plot_i,
  input  logic [NUM_LAYERS*X_W-1:0]      layer_x_i,
  input  logic [NUM_LAYERS*Y_W-1:0]      layer_y_i,
  input  logic [NUM_LAYERS*COLOUR_W-1:0] layer_colour_i,
  output logic                           vga_plot_o,
  output logic [X_W-1:0]                 vga_x_o,
  output logic [Y_W-1:0]                 vga_y_o,
  output logic [COLOUR_W-1:0]            vga_colour_o,
  output logic                           frame_busy_o,
  output logic                           frame_done_o,
  output logic                           timeout_o,
  output logic [7:0]                     overrun_cnt_o
);

  localparam int CUR_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam logic [CUR_W-1:0] LAST = CUR_W'(NUM_LAYERS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_NEXT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CUR_W-1:0]   cur_q, cur_d;
  logic               pending_q, pending_d;
  logic [TO_W-1:0]    wd_q, wd_d;
  logic               timeout_q, timeout_d;
  logic [7:0]         ovr_q, ovr_d;
  logic               vga_plot_q;
  logic [X_W-1:0]     vga_x_q;
  logic [Y_W-1:0]     vga_y_q;
  logic [COLOUR_W-1:0] vga_colour_q;

  logic tick_acc, busy, accept;

  assign tick_acc = run_i & frame_tick_i;
  assign busy     = (state_q != S_IDLE);
  assign accept   = (state_q == S_RUN) & layer_plot_i[cur_q];

  // Control state, layer index, watchdog, pending tick and sticky status.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q   <= S_IDLE;
      cur_q     <= '0;
      pending_q <= 1'b0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
      ovr_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      pending_q <= pending_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
      ovr_q     <= ovr_d;
    end
  end

  // Next-state sequencing through layers plus overrun bookkeeping.
  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    pending_d     = pending_q;
    wd_d          = wd_q;
    timeout_d     = timeout_q;
    ovr_d         = ovr_q;
    layer_start_o = '0;
    case (state_q)
      S_IDLE: begin
        if (tick_acc | pending_q) begin
          state_d   = S_START;
          pending_d = 1'b0;
        end
      end
      S_START: begin
        layer_start_o[cur_q] = 1'b1;
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        wd_d = wd_q + TO_W'(1);
        if (layer_done_i[cur_q]) begin
          state_d = S_NEXT;
        end else if (&wd_d) begin
          // Engine hung: skip it and flag, never restart the aborted layer.
          state_d   = S_NEXT;
          timeout_d = 1'b1;
        end
      end
      S_NEXT: begin
        if (cur_q == LAST) begin
          state_d = S_DONE;
        end else begin
          cur_d   = cur_q + CUR_W'(1);
          state_d = S_START;
        end
      end
      S_DONE: begin
        cur_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Only one frame is ever queued; extra ticks are just counted.
    if (tick_acc & (busy | pending_q)) begin
      if (ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
    end
    if (tick_acc & busy) pending_d = 1'b1;
  end

  // Registered pixel path; coordinates hold unless the active layer plots.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      vga_plot_q   <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
    end else begin
      vga_plot_q <= accept;
      if (accept) begin
        vga_x_q      <= layer_x_i[cur_q*X_W +: X_W];
        vga_y_q      <= layer_y_i[cur_q*Y_W +: Y_W];
        vga_colour_q <= layer_colour_i[cur_q*COLOUR_W +: COLOUR_W];
      end
    end
  end

  assign vga_plot_o    = vga_plot_q;
  assign vga_x_o       = vga_x_q;
  assign vga_y_o       = vga_y_q;
  assign vga_colour_o  = vga_colour_q;
  assign frame_busy_o  = busy;
  assign frame_done_o  = (state_q == S_DONE);
  assign timeout_o     = timeout_q;
  assign overrun_cnt_o = ovr_q;

endmodule
